// File: rtl/atm_session_ctrl.sv
// Session/menu sequencer in front of the ATM transaction core: button edges, menu navigation,
// the ready/status handshake for transactions, PIN lockout and inactivity logout.
//
// state        | meaning
// S_IDLE       | no session, waiting for card/account entry
// S_ACC_NUM    | account number entry, enter starts a core transaction
// S_PIN_INPUT  | PIN entry, enter starts a core transaction
// S_MENU       | main menu, enter picks a branch by menu_sel
// S_SHOW_BAL   | balances display
// S_CONVERT    | currency conversion start page
// S_SEL_CONV_1 | choose source currency
// S_SEL_CONV_2 | choose target currency, enter runs the conversion
// S_WITHDRAW   | withdraw start page
// S_SEL_AMT_WD | choose amount, enter runs the withdrawal
// S_TRANSFER   | transfer start page, enter validates the destination
// S_SEL_CUR_TR | choose transfer currency
// S_SEL_AMT_TR | choose amount, enter runs the transfer
// S_ERROR      | error message hold
// S_SUCCESS    | success message hold
module atm_session_ctrl #(
   parameter int STATUS_LAT    = 2,
   parameter int MSG_CYCLES    = 8,
   parameter int TIMEOUT       = 1000,
   parameter int MAX_PIN_TRIES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_enter,
   input  logic        btn_back,
   input  logic [1:0]  menu_sel,
   input  logic [3:0]  status_code,
   output logic [15:0] current_state,
   output logic        ready,
   output logic        busy,
   output logic        authenticated,
   output logic        locked
);

   localparam int LAT_W = $clog2(STATUS_LAT + 1);
   localparam int MSG_W = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(STATUS_LAT);
   localparam logic [MSG_W-1:0] MSG_LOAD = MSG_W'(MSG_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_ACC_NUM    = 4'd1,
      S_PIN_INPUT  = 4'd2,
      S_MENU       = 4'd3,
      S_SHOW_BAL   = 4'd4,
      S_CONVERT    = 4'd5,
      S_SEL_CONV_1 = 4'd6,
      S_SEL_CONV_2 = 4'd7,
      S_WITHDRAW   = 4'd8,
      S_SEL_AMT_WD = 4'd9,
      S_TRANSFER   = 4'd10,
      S_SEL_CUR_TR = 4'd11,
      S_SEL_AMT_TR = 4'd12,
      S_ERROR      = 4'd13,
      S_SUCCESS    = 4'd14
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic             enter_q;
   logic             back_q;
   logic             enter_ev;
   logic             back_ev;
   logic [LAT_W-1:0] lat_q;
   logic [MSG_W-1:0] msg_q;
   logic [TMO_W-1:0] tmo_q;
   logic [1:0]       fail_q;
   logic [1:0]       fail_inc;
   logic             is_msg;
   logic             is_txn;
   logic             start_txn;
   logic             set_auth;
   logic             clr_auth;
   logic             pin_fail;

   // Events are dropped entirely while a transaction is in flight.
   assign enter_ev = btn_enter & ~enter_q & ~busy;
   assign back_ev  = btn_back  & ~back_q  & ~busy;
   assign is_msg   = (state_q == S_ERROR) || (state_q == S_SUCCESS);
   assign fail_inc = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

   always_comb begin
      is_txn = 1'b0;
      case (state_q)
         S_ACC_NUM, S_PIN_INPUT, S_SEL_CONV_2,
         S_SEL_AMT_WD, S_TRANSFER, S_SEL_AMT_TR: is_txn = 1'b1;
         default:                                 is_txn = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      start_txn = 1'b0;
      set_auth  = 1'b0;
      clr_auth  = 1'b0;
      pin_fail  = 1'b0;
      if (busy) begin
         if (lat_q == '0) begin
            if (status_code == 4'd1) begin
               case (state_q)
                  S_ACC_NUM:   state_nxt = S_PIN_INPUT;
                  S_PIN_INPUT: begin
                     state_nxt = S_MENU;
                     set_auth  = 1'b1;
                  end
                  S_TRANSFER:  state_nxt = S_SEL_CUR_TR;
                  default:     state_nxt = S_SUCCESS;
               endcase
            end else begin
               state_nxt = S_ERROR;
               pin_fail  = (state_q == S_PIN_INPUT);
            end
         end
      end else if (back_ev) begin
         if (state_q != S_IDLE) begin
            if (authenticated && state_q != S_MENU) begin
               state_nxt = S_MENU;
            end else begin
               state_nxt = S_IDLE;
               clr_auth  = 1'b1;
            end
         end
      end else if (enter_ev && !is_msg) begin
         if (is_txn) begin
            start_txn = 1'b1;
         end else begin
            case (state_q)
               S_IDLE:       if (!locked) state_nxt = S_ACC_NUM;
               S_MENU: begin
                  case (menu_sel)
                     2'd0:    state_nxt = S_SHOW_BAL;
                     2'd1:    state_nxt = S_CONVERT;
                     2'd2:    state_nxt = S_WITHDRAW;
                     default: state_nxt = S_TRANSFER;
                  endcase
               end
               S_SHOW_BAL:   state_nxt = S_MENU;
               S_CONVERT:    state_nxt = S_SEL_CONV_1;
               S_SEL_CONV_1: state_nxt = S_SEL_CONV_2;
               S_WITHDRAW:   state_nxt = S_SEL_AMT_WD;
               S_SEL_CUR_TR: state_nxt = S_SEL_AMT_TR;
               default:      state_nxt = state_q;
            endcase
         end
      end else if (is_msg && msg_q == '0) begin
         state_nxt = authenticated ? S_MENU : S_IDLE;
      end else if (state_q != S_IDLE && !enter_ev && tmo_q == '0) begin
         state_nxt = S_IDLE;
         clr_auth  = 1'b1;
      end
   end

   always_comb begin
      current_state          = '0;
      current_state[state_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enter_q       <= 1'b0;
         back_q        <= 1'b0;
         ready         <= 1'b0;
         busy          <= 1'b0;
         lat_q         <= '0;
         msg_q         <= '0;
         tmo_q         <= '0;
         fail_q        <= 2'd0;
         authenticated <= 1'b0;
         locked        <= 1'b0;
      end else begin
         enter_q <= btn_enter;
         back_q  <= btn_back;
         ready   <= start_txn;

         // lat_q counts down to the status sampling cycle.
         if (start_txn) begin
            busy  <= 1'b1;
            lat_q <= LAT_LOAD;
         end else if (busy) begin
            if (lat_q == '0) begin
               busy <= 1'b0;
            end else begin
               lat_q <= lat_q - 1'b1;
            end
         end

         if (state_nxt != state_q && (state_nxt == S_ERROR || state_nxt == S_SUCCESS)) begin
            msg_q <= MSG_LOAD;
         end else if (is_msg && msg_q != '0) begin
            msg_q <= msg_q - 1'b1;
         end

         if (state_nxt != state_q || enter_ev || back_ev) begin
            tmo_q <= TMO_LOAD;
         end else if (state_q != S_IDLE && !busy && tmo_q != '0) begin
            tmo_q <= tmo_q - 1'b1;
         end

         if (set_auth) begin
            authenticated <= 1'b1;
         end else if (clr_auth) begin
            authenticated <= 1'b0;
         end

         if (set_auth) begin
            fail_q <= 2'd0;
         end else if (pin_fail) begin
            fail_q <= fail_inc;
         end

         if (pin_fail && 32'(fail_inc) >= MAX_PIN_TRIES) begin
            locked <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed session scenarios with literal expectations, then
// randomized button/status traffic checked every cycle against a timestamp-based model.
module tb_atm_session_ctrl;

   localparam int STATUS_LAT    = 2;
   localparam int MSG_CYCLES    = 8;
   localparam int TIMEOUT       = 1000;
   localparam int MAX_PIN_TRIES = 3;

   localparam logic [15:0] ST_IDLE  = 16'h0001;
   localparam logic [15:0] ST_ACC   = 16'h0002;
   localparam logic [15:0] ST_PIN   = 16'h0004;
   localparam logic [15:0] ST_MENU  = 16'h0008;
   localparam logic [15:0] ST_BAL   = 16'h0010;
   localparam logic [15:0] ST_CONV  = 16'h0020;
   localparam logic [15:0] ST_CC1   = 16'h0040;
   localparam logic [15:0] ST_CC2   = 16'h0080;
   localparam logic [15:0] ST_WD    = 16'h0100;
   localparam logic [15:0] ST_WDAMT = 16'h0200;
   localparam logic [15:0] ST_TR    = 16'h0400;
   localparam logic [15:0] ST_TRCUR = 16'h0800;
   localparam logic [15:0] ST_TRAMT = 16'h1000;
   localparam logic [15:0] ST_ERR   = 16'h2000;
   localparam logic [15:0] ST_OK    = 16'h4000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_enter = 1'b0;
   logic        btn_back = 1'b0;
   logic [1:0]  menu_sel = 2'd0;
   logic [3:0]  status_code = 4'd0;
   logic [15:0] current_state;
   logic        ready;
   logic        busy;
   logic        authenticated;
   logic        locked;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   atm_session_ctrl #(
      .STATUS_LAT(STATUS_LAT),
      .MSG_CYCLES(MSG_CYCLES),
      .TIMEOUT(TIMEOUT),
      .MAX_PIN_TRIES(MAX_PIN_TRIES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_enter(btn_enter),
      .btn_back(btn_back),
      .menu_sel(menu_sel),
      .status_code(status_code),
      .current_state(current_state),
      .ready(ready),
      .busy(busy),
      .authenticated(authenticated),
      .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_state;
   int          m_cyc = 0;
   int          m_txn_evt = -100;
   int          m_quiet, m_seen, m_fails;
   bit          m_auth, m_locked, m_ready, m_busy, m_pe, m_pb;

   function automatic bit is_txn(input logic [15:0] s);
      return s inside {ST_ACC, ST_PIN, ST_CC2, ST_WDAMT, ST_TR, ST_TRAMT};
   endfunction

   function automatic logic [15:0] nav(input logic [15:0] s, input logic [1:0] sel);
      logic [15:0] menu_dest [4];
      menu_dest = '{ST_BAL, ST_CONV, ST_WD, ST_TR};
      case (s)
         ST_IDLE:  return ST_ACC;
         ST_MENU:  return menu_dest[sel];
         ST_BAL:   return ST_MENU;
         ST_CONV:  return ST_CC1;
         ST_CC1:   return ST_CC2;
         ST_WD:    return ST_WDAMT;
         ST_TRCUR: return ST_TRAMT;
         default:  return s;
      endcase
   endfunction

   always @(posedge clk) begin : model
      bit          ev_e, ev_b, busy_now;
      logic [15:0] nxt;
      if (rst) begin
         m_state   = ST_IDLE;
         m_txn_evt = -100;
         m_quiet   = 0;
         m_seen    = 0;
         m_fails   = 0;
         m_auth    = 0;
         m_locked  = 0;
         m_ready   = 0;
         m_busy    = 0;
         m_pe      = 0;
         m_pb      = 0;
      end else begin
         busy_now = (m_cyc >= m_txn_evt + 1) && (m_cyc <= m_txn_evt + 1 + STATUS_LAT);
         ev_e = btn_enter && !m_pe && !busy_now;
         ev_b = btn_back && !m_pb && !busy_now;
         nxt  = m_state;
         if (busy_now) begin
            if (m_cyc == m_txn_evt + 1 + STATUS_LAT) begin
               if (status_code == 4'd1) begin
                  if (m_state == ST_ACC) nxt = ST_PIN;
                  else if (m_state == ST_PIN) begin
                     nxt = ST_MENU;
                     m_auth = 1;
                     m_fails = 0;
                  end else if (m_state == ST_TR) nxt = ST_TRCUR;
                  else nxt = ST_OK;
               end else begin
                  nxt = ST_ERR;
                  if (m_state == ST_PIN) begin
                     m_fails = (m_fails < 3) ? m_fails + 1 : 3;
                     if (m_fails >= MAX_PIN_TRIES) m_locked = 1;
                  end
               end
            end
         end else if (ev_b) begin
            if (m_state != ST_IDLE) begin
               if (m_auth && m_state != ST_MENU) nxt = ST_MENU;
               else begin
                  nxt = ST_IDLE;
                  m_auth = 0;
               end
            end
         end else if (ev_e && m_state != ST_OK && m_state != ST_ERR) begin
            if (is_txn(m_state)) m_txn_evt = m_cyc;
            else if (!(m_state == ST_IDLE && m_locked)) nxt = nav(m_state, menu_sel);
         end else begin
            if (m_state == ST_OK || m_state == ST_ERR) begin
               m_seen++;
               if (m_seen == MSG_CYCLES) nxt = m_auth ? ST_MENU : ST_IDLE;
            end
            if (nxt == m_state && m_state != ST_IDLE && !ev_e) begin
               m_quiet++;
               if (m_quiet == TIMEOUT) begin
                  nxt = ST_IDLE;
                  m_auth = 0;
               end
            end
         end
         if (nxt != m_state || ev_e || ev_b) m_quiet = 0;
         if (nxt != m_state) m_seen = 0;
         m_state = nxt;
         m_pe    = btn_enter;
         m_pb    = btn_back;
         m_ready = (m_txn_evt == m_cyc);
         m_busy  = (m_cyc + 1 >= m_txn_evt + 1) && (m_cyc + 1 <= m_txn_evt + 1 + STATUS_LAT);
      end
      m_cyc++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check16("model.current_state", current_state, m_state);
         check1("model.ready", ready, m_ready);
         check1("model.busy", busy, m_busy);
         check1("model.authenticated", authenticated, m_auth);
         check1("model.locked", locked, m_locked);
         check1("onehot", $onehot(current_state), 1'b1);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic press_enter();
      @(negedge clk) btn_enter = 1'b1;
      @(negedge clk) btn_enter = 1'b0;
   endtask

   task automatic press_both();
      @(negedge clk) begin btn_enter = 1'b1; btn_back = 1'b1; end
      @(negedge clk) begin btn_enter = 1'b0; btn_back = 1'b0; end
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      check16("reset.state", current_state, ST_IDLE);
      check1("reset.ready", ready, 1'b0);
      check1("reset.busy", busy, 1'b0);
      check1("reset.auth", authenticated, 1'b0);
      check1("reset.locked", locked, 1'b0);

      // login and handshake timing
      status_code = 4'd1;
      press_enter();
      check16("login.acc", current_state, ST_ACC);
      check1("login.nav_no_ready", ready, 1'b0);
      press_enter();
      check1("timing.ready_e1", ready, 1'b1);
      check1("timing.busy_e1", busy, 1'b1);
      check16("timing.state_held", current_state, ST_ACC);
      @(negedge clk);
      check1("timing.ready_e2", ready, 1'b0);
      check1("timing.busy_e2", busy, 1'b1);
      @(negedge clk);
      check1("timing.busy_e3", busy, 1'b1);
      check16("timing.state_e3", current_state, ST_ACC);
      @(negedge clk);
      check1("timing.busy_e4", busy, 1'b0);
      check16("timing.pin_e4", current_state, ST_PIN);
      press_enter();
      repeat (3) @(negedge clk);
      check16("login.menu", current_state, ST_MENU);
      check1("login.auth", authenticated, 1'b1);

      // withdraw to success and back to menu
      menu_sel = 2'd2;
      press_enter();
      check16("wd.withdraw", current_state, ST_WD);
      press_enter();
      check16("wd.amount", current_state, ST_WDAMT);
      press_enter();
      repeat (3) @(negedge clk);
      check16("wd.success", current_state, ST_OK);
      for (int i = 1; i < MSG_CYCLES; i++) begin
         @(negedge clk);
         check16("wd.success_hold", current_state, ST_OK);
      end
      @(negedge clk);
      check16("wd.back_to_menu", current_state, ST_MENU);

      // transfer rejected by the core
      menu_sel = 2'd3;
      press_enter();
      check16("tr.transfer", current_state, ST_TR);
      status_code = 4'd2;
      press_enter();
      check1("tr.ready", ready, 1'b1);
      repeat (3) @(negedge clk);
      check16("tr.error", current_state, ST_ERR);
      repeat (MSG_CYCLES) @(negedge clk);
      check16("tr.menu", current_state, ST_MENU);
      status_code = 4'd1;

      // enter and back together: back wins
      menu_sel = 2'd0;
      press_enter();
      check16("bal.show", current_state, ST_BAL);
      press_both();
      check16("bal.back_wins", current_state, ST_MENU);
      check1("bal.no_ready", ready, 1'b0);

      // inactivity logout from MENU
      repeat (TIMEOUT - 1) @(negedge clk);
      check16("tmo.still_menu", current_state, ST_MENU);
      @(negedge clk);
      check16("tmo.idle", current_state, ST_IDLE);
      check1("tmo.auth_cleared", authenticated, 1'b0);

      // PIN lockout after three rejections
      for (int k = 0; k < MAX_PIN_TRIES; k++) begin
         status_code = 4'd1;
         press_enter();
         press_enter();
         repeat (3) @(negedge clk);
         check16("lock.pin", current_state, ST_PIN);
         status_code = 4'd5;
         press_enter();
         repeat (3) @(negedge clk);
         check16("lock.error", current_state, ST_ERR);
         check1("lock.locked", locked, (k == MAX_PIN_TRIES - 1));
         repeat (MSG_CYCLES) @(negedge clk);
         check16("lock.idle", current_state, ST_IDLE);
      end
      status_code = 4'd1;
      press_enter();
      @(negedge clk);
      check16("lock.enter_ignored", current_state, ST_IDLE);
      do_reset();
      check1("lock.rst_clears", locked, 1'b0);

      // reset in the middle of a transaction
      press_enter();
      press_enter();
      check1("rstbusy.busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check16("rstbusy.idle", current_state, ST_IDLE);
      check1("rstbusy.busy_clr", busy, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check1("rstbusy.no_ready", ready, 1'b0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         rst         = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 2) == 0) btn_enter = ~btn_enter;
         if ($urandom_range(0, 11) == 0) btn_back = ~btn_back;
         menu_sel    = 2'($urandom_range(0, 3));
         status_code = ($urandom_range(0, 3) != 0) ? 4'd1 : 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
